// File: rtl/gv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gv_pkg
// Description : Shared game-view types for the leaderboard block: the 3-bit
//               game mode type, the FINISH mode code and the insertion FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package gv_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t FINISH = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INSERT = 2'd1,
        DONE   = 2'd2
    } lb_state_t;

endpackage : gv_pkg
`default_nettype wire

// File: rtl/finish_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : finish_edge_det
// Description : Emits trig on the first cycle that mode equals FINISH after a
//               cycle where it did not. Holding FINISH does not re-trigger.
//               Reset clears the history to "not FINISH", so FINISH present
//               on the first cycle after reset counts as an edge.
// Ports       : clk  - clock
//               rst  - asynchronous active-high reset
//               mode - current game mode
//               trig - combinational rising-edge indication
// Revision    : 1.0 - initial release
// ============================================================================
module finish_edge_det
    import gv_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  mode_t mode,
    output logic  trig
);

    logic w_is_finish;
    logic r_prev_finish;

    assign w_is_finish = (mode == FINISH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_finish <= 1'b0;
        end else begin
            r_prev_finish <= w_is_finish;
        end
    end

    assign trig = w_is_finish && !r_prev_finish;

endmodule : finish_edge_det
`default_nettype wire

// File: rtl/leaderboard_tracker.sv
`default_nettype none
// ============================================================================
// Module      : leaderboard_tracker
// Description : Keeps a DEPTH-entry high-score table sorted non-increasing.
//               A FINISH edge captures the score and a bubble-insertion walks
//               the table one entry per cycle, then pulses done and reports
//               the rank at which the score was placed (DEPTH = not placed).
// Ports       : clk, rst       - clock, asynchronous active-high reset
//               score          - score captured on the trigger cycle
//               mode           - game mode (FINISH edge starts an insertion)
//               rd_idx/rd_score- combinational table read port
//               highest_score  - table entry 0
//               busy, done     - insertion in progress / completion pulse
//               rank           - placement of last inserted score
//               clr            - (LB_CLEAR_EN only) clear table while idle
// Config      : LB_CLEAR_EN - when defined, adds the clr input.
// Revision    : 1.0 - initial release
// ============================================================================
module leaderboard_tracker
    import gv_pkg::*;
#(
    parameter int SCORE_W = 8,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef LB_CLEAR_EN
    input  logic                       clr,
`endif
    input  logic [SCORE_W-1:0]         score,
    input  mode_t                      mode,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [SCORE_W-1:0]         rd_score,
    output logic [SCORE_W-1:0]         highest_score,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH+1)-1:0] rank
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int RANK_W = $clog2(DEPTH+1);
    localparam logic [RANK_W-1:0] c_NOT_PLACED = RANK_W'(DEPTH);
    localparam logic [IDX_W-1:0]  c_LAST_IDX   = IDX_W'(DEPTH-1);

    lb_state_t           r_state;
    lb_state_t           w_next_state;
    logic                w_trig;
    logic                w_clr;
    logic [SCORE_W-1:0]  r_table [DEPTH];
    logic [SCORE_W-1:0]  r_cand;
    logic [IDX_W-1:0]    r_idx;
    logic [RANK_W-1:0]   r_rank_tmp;
    logic [RANK_W-1:0]   r_rank;

`ifdef LB_CLEAR_EN
    assign w_clr = clr;
`else
    assign w_clr = 1'b0;
`endif

    finish_edge_det u_finish_edge_det (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .trig (w_trig)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and status outputs. Triggers outside IDLE are simply
    // ignored, which is what drops them while busy or in DONE.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                // clear takes priority; a same-cycle trigger is lost
                if (w_trig && !w_clr) begin
                    w_next_state = INSERT;
                end
            end
            INSERT: begin
                busy = 1'b1;
                if (r_idx == c_LAST_IDX) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Table and insertion datapath. Each INSERT step keeps the larger of
    // cand/table[idx] in the table and carries the smaller one down; the
    // strict compare gives existing (older) entries priority on ties.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= '0;
            end
            r_cand     <= '0;
            r_idx      <= '0;
            r_rank_tmp <= c_NOT_PLACED;
            r_rank     <= c_NOT_PLACED;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_clr) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            r_table[i] <= '0;
                        end
                        r_rank <= c_NOT_PLACED;
                    end else if (w_trig) begin
                        r_cand     <= score;
                        r_idx      <= '0;
                        r_rank_tmp <= c_NOT_PLACED;
                    end
                end
                INSERT: begin
                    if (r_cand > r_table[r_idx]) begin
                        r_table[r_idx] <= r_cand;
                        r_cand         <= r_table[r_idx];
                        // only the first swap marks where the new score landed
                        if (r_rank_tmp == c_NOT_PLACED) begin
                            r_rank_tmp <= RANK_W'(r_idx);
                        end
                    end
                    r_idx <= r_idx + IDX_W'(1);
                end
                DONE: begin
                    r_rank <= r_rank_tmp;
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read port and outputs
    // ------------------------------------------------------------------
    always_comb begin
        rd_score = '0;
        if (int'(rd_idx) < DEPTH) begin
            rd_score = r_table[rd_idx];
        end
    end

    assign highest_score = r_table[0];
    assign rank          = r_rank;

endmodule : leaderboard_tracker
`default_nettype wire

// File: tb/tb_leaderboard_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_leaderboard_tracker
// Description : Directed self-checking bench for leaderboard_tracker
//               (DEPTH=4, SCORE_W=8) with hand-computed expected tables.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_leaderboard_tracker;
    import gv_pkg::*;

    localparam int SCORE_W = 8;
    localparam int DEPTH   = 4;

    logic         clk;
    logic         rst;
    logic [7:0]   score;
    mode_t        mode;
    logic [1:0]   rd_idx;
    logic [7:0]   rd_score;
    logic [7:0]   highest_score;
    logic         busy;
    logic         done;
    logic [2:0]   rank;

    int n_checks = 0;
    int n_errors = 0;

    leaderboard_tracker #(
        .SCORE_W (SCORE_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef LB_CLEAR_EN
        .clr           (1'b0),
`endif
        .score         (score),
        .mode          (mode),
        .rd_idx        (rd_idx),
        .rd_score      (rd_score),
        .highest_score (highest_score),
        .busy          (busy),
        .done          (done),
        .rank          (rank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_table(input string tag, input int e0, input int e1,
                               input int e2, input int e3);
        int exp_t [4];
        exp_t = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            #1;
            check($sformatf("%s[%0d]", tag, i), int'(rd_score), exp_t[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        mode = 3'b000;
        rst  = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        @(negedge clk);
    endtask

    // Drive one FINISH edge with score s, hold FINISH for 'hold' negedges,
    // then watch done for a bounded window. lat is the negedge index (after
    // the trigger edge) where done was first seen, -1 if never.
    task automatic do_entry(input logic [7:0] s, input int hold,
                            output int lat, output int ndone);
        lat   = -1;
        ndone = 0;
        @(negedge clk);
        mode  = FINISH;
        score = s;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (lat < 0) lat = k;
            end
            if (k == hold) mode = 3'b000;
        end
        if (lat < 0) check("done_timeout", 0, 1);
    endtask

    int lat, nd;

    initial begin
        rst    = 1'b1;
        mode   = 3'b000;
        score  = '0;
        rd_idx = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        check("rst_highest", int'(highest_score), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rank", int'(rank), 4);
        check_table("rst_tab", 0, 0, 0, 0);

        // single entry, latency and busy profile
        @(negedge clk);
        mode  = FINISH;
        score = 8'd50;
        lat   = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("busy_k1", int'(busy), 1);
                mode = 3'b000;
            end
            if (k == 4) check("busy_k4", int'(busy), 1);
            if (k == 5) check("busy_done_cyc", int'(busy), 0);
            if (done && lat < 0) lat = k;
        end
        check("latency", lat, 5);
        check("e50_rank", int'(rank), 0);
        check("e50_highest", int'(highest_score), 50);
        check_table("e50_tab", 50, 0, 0, 0);

        // sequential entries, 10 shifted out by 90
        do_reset();
        do_entry(8'd30, 1, lat, nd);
        do_entry(8'd70, 1, lat, nd);
        do_entry(8'd50, 1, lat, nd);
        check("e50b_rank", int'(rank), 1);
        do_entry(8'd10, 1, lat, nd);
        check("e10_rank", int'(rank), 3);
        do_entry(8'd90, 1, lat, nd);
        check("e90_rank", int'(rank), 0);
        check("e90_highest", int'(highest_score), 90);
        check_table("seq_tab", 90, 70, 50, 30);

        // score too low to place
        do_entry(8'd20, 1, lat, nd);
        check("e20_ndone", nd, 1);
        check("e20_rank", int'(rank), 4);
        check_table("e20_tab", 90, 70, 50, 30);

        // tie goes below existing entry
        do_reset();
        do_entry(8'd70, 1, lat, nd);
        do_entry(8'd50, 1, lat, nd);
        check_table("pre_tie", 70, 50, 0, 0);
        do_entry(8'd50, 1, lat, nd);
        check("tie_rank", int'(rank), 2);
        check_table("tie_tab", 70, 50, 50, 0);

        // zero never places
        do_entry(8'd0, 1, lat, nd);
        check("zero_rank", int'(rank), 4);
        check("zero_ndone", nd, 1);

        // FINISH held 20 cycles: one done only
        do_entry(8'd60, 20, lat, nd);
        check("hold_ndone", nd, 1);
        check("hold_rank", int'(rank), 1);
        check_table("hold_tab", 70, 60, 50, 50);

        // new FINISH edge while busy is dropped
        @(negedge clk);
        mode  = FINISH;
        score = 8'd5;
        nd    = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) nd++;
            if (k == 1) mode = 3'b000;
            if (k == 2) begin
                mode  = FINISH;
                score = 8'd99;
            end
            if (k == 3) mode = 3'b000;
        end
        check("busy_retrig_ndone", nd, 1);
        check("busy_retrig_rank", int'(rank), 4);
        check_table("busy_retrig_tab", 70, 60, 50, 50);

        // reset during the second INSERT cycle
        @(negedge clk);
        mode  = FINISH;
        score = 8'd80;
        @(negedge clk);
        mode = 3'b000;
        @(negedge clk);
        check("pre_abort_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_rank", int'(rank), 4);
        check("abort_highest", int'(highest_score), 0);
        @(negedge clk);
        rst = 1'b0;
        nd  = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("abort_ndone", nd, 0);
        check_table("abort_tab", 0, 0, 0, 0);

        // FINISH present through reset counts on the first cycle after it
        @(negedge clk);
        rst   = 1'b1;
        mode  = FINISH;
        score = 8'd33;
        @(negedge clk);
        rst = 1'b0;
        nd  = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        mode = 3'b000;
        check("post_rst_ndone", nd, 1);
        check("post_rst_highest", int'(highest_score), 33);
        check("post_rst_rank", int'(rank), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_leaderboard_tracker
`default_nettype wire
